// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared state, operand-kind and mode definitions for fetch_sequencer
package fetch_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_CAPTURE,
        ST_OP_REQ,
        ST_OP_CAPTURE,
        ST_ISSUE,
        ST_HALTED
    } state_e;

    typedef enum logic [1:0] {
        KIND_NONE  = 2'b00,
        KIND_PEEK  = 2'b01,
        KIND_PLOAD = 2'b10,
        KIND_VLOAD = 2'b11
    } kind_e;

    // Routing selects understood by datapath_controller.
    localparam int MODE_FETCH = 0;
    localparam int MODE_PEEK  = 1;
    localparam int MODE_PLOAD = 2;
    localparam int MODE_VLOAD = 3;

    function automatic int kind_to_mode(input kind_e kind);
        case (kind)
            KIND_PEEK:  return MODE_PEEK;
            KIND_PLOAD: return MODE_PLOAD;
            KIND_VLOAD: return MODE_VLOAD;
            default:    return MODE_FETCH;
        endcase
    endfunction

endpackage

// File: rtl/program_counter.sv
// rtl/program_counter.sv - wrapping program counter with load-over-increment priority
module program_counter #(
    parameter int ADDR_SIZE = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 inc,
    input  logic                 load,
    input  logic [ADDR_SIZE-1:0] load_addr,
    output logic [ADDR_SIZE-1:0] pc
);

    logic [ADDR_SIZE-1:0] pc_q;
    logic [ADDR_SIZE-1:0] pc_d;

    // Increment wraps naturally at 2^ADDR_SIZE.
    always_comb begin
        pc_d = pc_q;
        if (load) begin
            pc_d = load_addr;
        end else if (inc) begin
            pc_d = pc_q + ADDR_SIZE'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - instruction/operand fetch FSM with valid/ready issue; FETCH_SEQUENCER_JUMP_EN enables jump loads
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int WORD_SIZE        = 16,
    parameter int ADDR_SIZE        = 8,
    parameter int MODE_SELECT_SIZE = 3
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic                        halt_req,
    input  logic [WORD_SIZE-1:0]        instruction,
    input  logic [WORD_SIZE-1:0]        peek,
    input  logic [WORD_SIZE-1:0]        load,
    output logic [MODE_SELECT_SIZE-1:0] mode,
    output logic [ADDR_SIZE-1:0]        p_ram_addr,
    output logic [ADDR_SIZE-1:0]        v_ram_addr,
    output logic [ADDR_SIZE-1:0]        pc,
    output logic                        issue_valid,
    input  logic                        issue_ready,
    output logic [WORD_SIZE-1:0]        issue_instr,
    output logic [WORD_SIZE-1:0]        issue_operand,
    output logic                        halted,
    input  logic                        jump_valid,
    input  logic [ADDR_SIZE-1:0]        jump_addr
);

    state_e               state_q;
    state_e               state_d;
    logic [WORD_SIZE-1:0] issue_instr_q;
    logic [WORD_SIZE-1:0] issue_operand_q;
    kind_e                cur_kind;
    kind_e                new_kind;
    logic                 handshake;
    logic                 pc_inc;
    logic                 pc_load;
    logic [ADDR_SIZE-1:0] pc_load_addr;
    logic [ADDR_SIZE-1:0] pc_cur;

    // cur_kind is valid from OP_REQ on; new_kind decodes the word arriving in CAPTURE.
    assign cur_kind  = kind_e'(issue_instr_q[WORD_SIZE-1:WORD_SIZE-2]);
    assign new_kind  = kind_e'(instruction[WORD_SIZE-1:WORD_SIZE-2]);
    assign handshake = (state_q == ST_ISSUE) && issue_ready;

    assign pc_inc = (state_q == ST_CAPTURE) ||
                    ((state_q == ST_OP_CAPTURE) && (cur_kind == KIND_PLOAD));

`ifdef FETCH_SEQUENCER_JUMP_EN
    assign pc_load      = handshake && jump_valid;
    assign pc_load_addr = jump_addr;
`else
    logic unused_jump;
    assign unused_jump  = ^{jump_valid, jump_addr};
    assign pc_load      = 1'b0;
    assign pc_load_addr = '0;
`endif

    program_counter #(
        .ADDR_SIZE (ADDR_SIZE)
    ) u_program_counter (
        .clk       (clk),
        .rst_n     (rst_n),
        .inc       (pc_inc),
        .load      (pc_load),
        .load_addr (pc_load_addr),
        .pc        (pc_cur)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:       if (start) state_d = ST_FETCH;
            ST_FETCH:      state_d = ST_CAPTURE;
            ST_CAPTURE:    state_d = (new_kind == KIND_NONE) ? ST_ISSUE : ST_OP_REQ;
            ST_OP_REQ:     state_d = ST_OP_CAPTURE;
            ST_OP_CAPTURE: state_d = ST_ISSUE;
            ST_ISSUE:      if (handshake) state_d = halt_req ? ST_HALTED : ST_FETCH;
            ST_HALTED:     if (start) state_d = ST_FETCH;
            default:       state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        mode        = MODE_SELECT_SIZE'(MODE_FETCH);
        p_ram_addr  = '0;
        v_ram_addr  = '0;
        issue_valid = 1'b0;
        halted      = 1'b0;
        case (state_q)
            ST_FETCH, ST_CAPTURE: begin
                p_ram_addr = pc_cur;
            end
            // mode is held into OP_CAPTURE because the routing mux is combinational.
            ST_OP_REQ, ST_OP_CAPTURE: begin
                mode = MODE_SELECT_SIZE'(kind_to_mode(cur_kind));
                if (cur_kind == KIND_VLOAD) begin
                    v_ram_addr = issue_instr_q[ADDR_SIZE-1:0];
                end else begin
                    p_ram_addr = pc_cur;
                end
            end
            ST_ISSUE:  issue_valid = 1'b1;
            ST_HALTED: halted = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            issue_instr_q   <= '0;
            issue_operand_q <= '0;
        end else if (state_q == ST_CAPTURE) begin
            issue_instr_q   <= instruction;
            issue_operand_q <= '0;
        end else if (state_q == ST_OP_CAPTURE) begin
            issue_operand_q <= (cur_kind == KIND_PEEK) ? peek : load;
        end
    end

    assign pc            = pc_cur;
    assign issue_instr   = issue_instr_q;
    assign issue_operand = issue_operand_q;

endmodule
